// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants, state type and helpers for the iterative divider
package div_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } div_state_e;

  // Two's-complement negate as inverters plus increment.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/cla_16b.sv
// rtl/cla_16b.sv - 16-bit two-level carry-lookahead adder (4-bit groups)
module cla_16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  gg;
  logic [3:0]  pg;
  logic [4:0]  gc;
  logic [15:0] c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    gg = '0;
    pg = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg[k] = &p[4*k +: 4];
    end
  end

  // Group carries are fully expanded from c_in so no carry depends on another carry bit.
  always_comb begin
    gc    = '0;
    gc[0] = c_in;
    gc[1] = gg[0] | (pg[0] & c_in);
    gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & c_in);
    gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]) | (pg[2] & pg[1] & pg[0] & c_in);
    gc[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1]) | (pg[3] & pg[2] & pg[1] & gg[0])
          | (pg[3] & pg[2] & pg[1] & pg[0] & c_in);
  end

  always_comb begin
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
  end

  assign sum   = p ^ c;
  assign c_out = gc[4];

endmodule

// File: rtl/iter_divider_16b.sv
// rtl/iter_divider_16b.sv - 16-cycle restoring divider, signed/unsigned, with overflow and divide-by-zero flags
module iter_divider_16b #(
  parameter int WIDTH = div_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] InA,
  input  logic [WIDTH-1:0] InB,
  input  logic             sign,
  output logic [WIDTH-1:0] Quo,
  output logic [WIDTH-1:0] Rem,
  output logic             busy,
  output logic             done,
  output logic             Ofl,
  output logic             DivZero
);
  import div_pkg::*;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             ofl_pend_q, ofl_pend_d;
  logic [WIDTH-1:0] quo_o_q, quo_o_d;
  logic [WIDTH-1:0] rem_o_q, rem_o_d;
  logic             ofl_q, ofl_d;
  logic             divz_q, divz_d;

  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH-1:0] diff;
  logic             cout;
  logic             ge;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // Low 16 bits of the shifted partial remainder; its 17th bit is rem_q's MSB.
  assign rem_sh = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};

  cla_16b u_cla (
    .a    (rem_sh),
    .b    (~dvs_q),
    .c_in (1'b1),
    .sum  (diff),
    .c_out(cout)
  );

  // 17-bit difference is non-negative when the shifted-out bit or the carry covers the borrow.
  assign ge       = rem_q[WIDTH-1] | cout;
  assign rem_step = ge ? diff : rem_sh;
  assign quo_step = {quo_q[WIDTH-2:0], ge};
  assign a_mag    = (sign && InA[WIDTH-1]) ? neg_w(InA) : InA;
  assign b_mag    = (sign && InB[WIDTH-1]) ? neg_w(InB) : InB;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    ofl_pend_d = ofl_pend_q;
    quo_o_d    = quo_o_q;
    rem_o_d    = rem_o_q;
    ofl_d      = ofl_q;
    divz_d     = divz_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ofl_d  = 1'b0;
          divz_d = 1'b0;
          if (InB == '0) begin
            state_d = ST_FIN;
            quo_o_d = '1;
            rem_o_d = InA;
            divz_d  = 1'b1;
          end else begin
            state_d    = ST_CALC;
            cnt_d      = '1;
            rem_d      = '0;
            quo_d      = a_mag;
            dvs_d      = b_mag;
            neg_quo_d  = sign & (InA[WIDTH-1] ^ InB[WIDTH-1]);
            neg_rem_d  = sign & InA[WIDTH-1];
            ofl_pend_d = sign && (InA == {1'b1, {(WIDTH-1){1'b0}}}) && (InB == '1);
          end
        end
      end
      ST_CALC: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_FIN;
          cnt_d   = '0;
          quo_o_d = neg_quo_q ? neg_w(quo_step) : quo_step;
          rem_o_d = neg_rem_q ? neg_w(rem_step) : rem_step;
          ofl_d   = ofl_pend_q;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      ofl_pend_q <= 1'b0;
      quo_o_q    <= '0;
      rem_o_q    <= '0;
      ofl_q      <= 1'b0;
      divz_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      ofl_pend_q <= ofl_pend_d;
      quo_o_q    <= quo_o_d;
      rem_o_q    <= rem_o_d;
      ofl_q      <= ofl_d;
      divz_q     <= divz_d;
    end
  end

  assign Quo     = quo_o_q;
  assign Rem     = rem_o_q;
  assign Ofl     = ofl_q;
  assign DivZero = divz_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_FIN);

endmodule

// File: tb/tb_iter_divider_16b.sv
// tb/tb_iter_divider_16b.sv - scoreboard bench for iter_divider_16b against an arithmetic reference model
module tb_iter_divider_16b;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] InA;
  logic [15:0] InB;
  logic        sign;
  logic [15:0] Quo;
  logic [15:0] Rem;
  logic        busy;
  logic        done;
  logic        Ofl;
  logic        DivZero;

  iter_divider_16b #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .InA(InA), .InB(InB), .sign(sign),
    .Quo(Quo), .Rem(Rem), .busy(busy), .done(done), .Ofl(Ofl), .DivZero(DivZero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        ofl;
    logic        dz;
    int          lat;
    int          sc;
  } exp_t;

  exp_t sb[$];
  exp_t last_e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
    exp_t e;
    int ia, ib, q, r;
    e.ofl = 1'b0;
    e.dz  = 1'b0;
    e.sc  = 0;
    if (s) begin
      ia = int'($signed(a));
      ib = int'($signed(b));
    end else begin
      ia = int'({16'd0, a});
      ib = int'({16'd0, b});
    end
    if (ib == 0) begin
      e.q  = 16'hFFFF;
      e.r  = a;
      e.dz = 1'b1;
      e.lat = 1;
    end else begin
      e.lat = 17;
      if (s && ia == -32768 && ib == -1) begin
        q = -32768;
        r = 0;
        e.ofl = 1'b1;
      end else begin
        q = ia / ib;
        r = ia % ib;
      end
      e.q = q[15:0];
      e.r = r[15:0];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("done_without_request", {31'd0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        last_e = e;
        chk("quo",     {16'd0, Quo}, {16'd0, e.q});
        chk("rem",     {16'd0, Rem}, {16'd0, e.r});
        chk("ofl",     {31'd0, Ofl}, {31'd0, e.ofl});
        chk("divzero", {31'd0, DivZero}, {31'd0, e.dz});
        chk("latency", cyc - e.sc + 1, e.lat);
        chk("busy_with_done", {31'd0, busy}, 32'd1);
      end
    end
  end

  // Called at a negedge; waits for IDLE, then pulses start for one cycle.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s, input bit expect_it);
    int n = 0;
    exp_t e;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", {31'd0, busy}, 32'd0);
    InA   = a;
    InB   = b;
    sign  = s;
    start = 1'b1;
    if (expect_it) begin
      e = model(a, b, s);
      e.sc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    rst   = 1'b1;
    start = 1'b0;
    InA   = '0;
    InB   = '0;
    sign  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_quo",  {16'd0, Quo}, 32'd0);
    chk("rst_rem",  {16'd0, Rem}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ofl",  {31'd0, Ofl}, 32'd0);
    chk("rst_dz",   {31'd0, DivZero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(16'd100, 16'd7, 1'b0, 1);
    issue(16'hFFF9, 16'd2, 1'b1, 1);
    issue(16'h8000, 16'hFFFF, 1'b1, 1);
    issue(16'h8000, 16'hFFFF, 1'b0, 1);
    issue(16'd1234, 16'd0, 1'b0, 1);
    drain();

    repeat (4) @(negedge clk);
    chk("hold_quo", {16'd0, Quo}, {16'd0, last_e.q});
    chk("hold_rem", {16'd0, Rem}, {16'd0, last_e.r});
    chk("hold_dz",  {31'd0, DivZero}, {31'd0, last_e.dz});

    // Re-pulse start during CALC cycle 5 with different operands; must be ignored.
    issue(16'd1000, 16'd3, 1'b0, 1);
    repeat (4) @(negedge clk);
    InA   = 16'd55;
    InB   = 16'd0;
    sign  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_repulse", {31'd0, busy}, 32'd1);
    drain();

    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 9))
        0: rb = 16'd0;
        1: rb = 16'hFFFF;
        2: rb = 16'd1;
        3: ra = 16'h8000;
        default: ;
      endcase
      issue(ra, rb, 1'($urandom_range(0, 1)), 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    // Abort mid-CALC: no done may follow, outputs return to zero.
    issue(16'd5000, 16'd9, 1'b0, 0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_quo",  {16'd0, Quo}, 32'd0);
    chk("abort_rem",  {16'd0, Rem}, 32'd0);
    chk("abort_ofl",  {31'd0, Ofl}, 32'd0);
    chk("abort_dz",   {31'd0, DivZero}, 32'd0);
    repeat (20) @(negedge clk);
    issue(16'hFFFF, 16'd1, 1'b0, 1);
    drain();

    // Reset wins over a simultaneous start.
    rst   = 1'b1;
    start = 1'b1;
    InA   = 16'd9;
    InB   = 16'd3;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_priority_busy", {31'd0, busy}, 32'd0);
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
